// File: rtl/run_sequencer.sv
// Program-run sequencer: launches a selected program slot on the core, gates it while it runs,
// and reports completion, watchdog timeouts and per-slot cycle statistics.
module run_sequencer #(
  parameter int PC_W        = 10,
  parameter int NUM_PROGS   = 4,
  parameter int SEL_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 0,
  parameter logic [NUM_PROGS*PC_W-1:0] PROG_BASE = {10'd384, 10'd256, 10'd128, 10'd0}
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             CoreHalt,
  input  logic [SEL_W-1:0] StatSel,
  output logic             CoreEn,
  output logic             PCLoad,
  output logic [PC_W-1:0]  PCLoadAddr,
  output logic             Ack,
  output logic             Busy,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCt,
  output logic [CNT_W-1:0] StatCycles
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [SEL_W-1:0] SEL_MASK = SEL_W'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stats_q [NUM_PROGS];
  logic [CNT_W-1:0] stats_d [NUM_PROGS];

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stats_d   = stats_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      IDLE, DONE: begin
        if (Start) state_d = LOAD;
      end
      LOAD: begin
        if (!Start) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        // Abort outranks halt, and halt outranks the watchdog.
        if (Start) begin
          state_d = LOAD;
        end else if (CoreHalt) begin
          state_d         = DONE;
          timeout_d       = 1'b0;
          stats_d[slot_q] = cnt_inc;
        end else if (TIMEOUT_CYC != 0 && int'(cnt_q) + 1 == TIMEOUT_CYC) begin
          state_d         = DONE;
          timeout_d       = 1'b1;
          stats_d[slot_q] = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture the slot on the edge entering LOAD too, so PCLoadAddr is right in the first LOAD cycle.
    if (state_d == LOAD) begin
      slot_d    = ProgSel & SEL_MASK;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < NUM_PROGS; i++) stats_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      stats_q   <= stats_d;
    end
  end

  assign CoreEn     = (state_q == RUN);
  assign Busy       = (state_q == RUN);
  assign PCLoad     = (state_q == LOAD);
  assign Ack        = (state_q == DONE);
  assign Timeout    = timeout_q;
  assign CycleCt    = cnt_q;
  assign PCLoadAddr = PROG_BASE[slot_q*PC_W +: PC_W];
  assign StatCycles = stats_q[StatSel & SEL_MASK];

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: expected run results are queued at launch and checked on Ack.
module tb_run_sequencer;

  typedef struct {
    int ct;
    int to;
  } exp_t;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, Start, CoreHalt;
  logic [1:0]  ProgSel, StatSel;
  logic        CoreEn, PCLoad, Ack, Busy, Timeout;
  logic [9:0]  PCLoadAddr;
  logic [15:0] CycleCt, StatCycles;

  logic        b_start, b_halt;
  logic [1:0]  b_prog_sel, b_stat_sel;
  logic        b_core_en, b_pc_load, b_ack, b_busy, b_timeout;
  logic [9:0]  b_pc_load_addr;
  logic [3:0]  b_cycle_ct, b_stat_cycles;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t qa[$];
  exp_t qb[$];
  int   base_addr[4] = '{0, 128, 256, 384};

  run_sequencer #(.TIMEOUT_CYC(20)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .CoreHalt(CoreHalt),
    .StatSel(StatSel), .CoreEn(CoreEn), .PCLoad(PCLoad), .PCLoadAddr(PCLoadAddr),
    .Ack(Ack), .Busy(Busy), .Timeout(Timeout), .CycleCt(CycleCt), .StatCycles(StatCycles)
  );

  run_sequencer #(.CNT_W(4)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(b_start), .ProgSel(b_prog_sel), .CoreHalt(b_halt),
    .StatSel(b_stat_sel), .CoreEn(b_core_en), .PCLoad(b_pc_load), .PCLoadAddr(b_pc_load_addr),
    .Ack(b_ack), .Busy(b_busy), .Timeout(b_timeout), .CycleCt(b_cycle_ct),
    .StatCycles(b_stat_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitors: one result per rising Ack.
  logic ack_prev_a = 1'b0;
  logic ack_prev_b = 1'b0;

  always @(negedge Clk) begin
    if (!Reset && Ack && !ack_prev_a) begin
      if (qa.size() == 0) begin
        chk("a_spurious_ack", 32'(Ack), 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_cycle_ct", 32'(CycleCt), e.ct);
        chk("a_timeout", 32'(Timeout), e.to);
        chk("a_stat_cycles", 32'(StatCycles), e.ct);
      end
    end
    ack_prev_a <= Ack;
  end

  always @(negedge Clk) begin
    if (!Reset && b_ack && !ack_prev_b) begin
      if (qb.size() == 0) begin
        chk("b_spurious_ack", 32'(b_ack), 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_cycle_ct", 32'(b_cycle_ct), e.ct);
        chk("b_timeout", 32'(b_timeout), e.to);
        chk("b_stat_cycles", 32'(b_stat_cycles), e.ct);
      end
    end
    ack_prev_b <= b_ack;
  end

  // Hold Start for k LOAD cycles; returns at the negedge where Start is dropped.
  task automatic launch(input int slot, input int k);
    ProgSel = 2'(slot);
    StatSel = 2'(slot);
    Start   = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge Clk);
      chk("load_pcload", 32'(PCLoad), 1);
      chk("load_addr", 32'(PCLoadAddr), base_addr[slot]);
      chk("load_ack", 32'(Ack), 0);
      chk("load_core_en", 32'(CoreEn), 0);
    end
    Start = 1'b0;
  endtask

  task automatic run_cycles(input int n, input bit halt);
    for (int c = 1; c <= n; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        chk("run_pcload", 32'(PCLoad), 0);
        chk("run_core_en", 32'(CoreEn), 1);
        chk("run_busy", 32'(Busy), 1);
        chk("run_ct_first", 32'(CycleCt), 0);
      end
      if (c == n && halt) CoreHalt = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit halt);
    int  waited = 0;
    bit  seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      CoreHalt = 1'b0;
      if (Ack) seen = 1;
      else waited++;
    end
    if (!seen) chk("ack_wait", 32'(Ack), 1);
    else if (halt) chk("halt_ack_latency", waited, 0);
  endtask

  task automatic do_run(input int slot, input int k, input int n, input bit halt,
                        input int exp_ct, input int exp_to);
    exp_t e;
    @(negedge Clk);
    e.ct = exp_ct;
    e.to = exp_to;
    qa.push_back(e);
    launch(slot, k);
    run_cycles(n, halt);
    wait_ack(halt);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; CoreHalt = 1'b0; ProgSel = '0; StatSel = '0;
    b_start = 1'b0; b_halt = 1'b0; b_prog_sel = '0; b_stat_sel = '0;
    repeat (2) @(negedge Clk);
    chk("rst_core_en", 32'(CoreEn), 0);
    chk("rst_pcload", 32'(PCLoad), 0);
    chk("rst_ack", 32'(Ack), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_addr", 32'(PCLoadAddr), 0);
    chk("rst_ct", 32'(CycleCt), 0);
    chk("rst_timeout", 32'(Timeout), 0);
    chk("rst_stat", 32'(StatCycles), 0);
    Reset = 1'b0;

    // Basic run, then Ack must hold and a ProgSel change in DONE must not move the address.
    do_run(2, 3, 5, 1, 5, 0);
    ProgSel = 2'd3;
    repeat (3) @(negedge Clk);
    chk("done_ack_hold", 32'(Ack), 1);
    chk("done_addr", 32'(PCLoadAddr), 256);
    chk("done_core_en", 32'(CoreEn), 0);
    chk("done_ct_hold", 32'(CycleCt), 5);

    do_run(1, 2, 7, 1, 7, 0);
    do_run(3, 1, 2, 1, 2, 0);
    @(negedge Clk);
    StatSel = 2'd1; #1 chk("stat_slot1", 32'(StatCycles), 7);
    StatSel = 2'd2; #1 chk("stat_slot2", 32'(StatCycles), 5);

    // Abort: slot 0 holds 6 from a completed run, then an aborted run must leave it alone.
    do_run(0, 1, 6, 1, 6, 0);
    @(negedge Clk);
    launch(0, 1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      if (c == 4) begin
        CoreHalt = 1'b1;
        Start    = 1'b1;
      end
    end
    @(negedge Clk);
    CoreHalt = 1'b0;
    chk("abort_pcload", 32'(PCLoad), 1);
    chk("abort_ack", 32'(Ack), 0);
    chk("abort_addr", 32'(PCLoadAddr), 0);
    chk("abort_ct_clear", 32'(CycleCt), 0);
    chk("abort_stat_kept", 32'(StatCycles), 6);
    Start = 1'b0;
    begin
      exp_t e;
      e.ct = 3;
      e.to = 0;
      qa.push_back(e);
    end
    run_cycles(3, 1);
    wait_ack(1);

    // Watchdog fires after 20 cycles; a halt in cycle 20 beats it.
    do_run(2, 1, 1, 0, 20, 1);
    do_run(2, 1, 20, 1, 20, 0);

    // Reset between edges in the middle of a run.
    @(negedge Clk);
    launch(1, 1);
    run_cycles(3, 0);
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_core_en", 32'(CoreEn), 0);
    chk("mid_rst_busy", 32'(Busy), 0);
    chk("mid_rst_pcload", 32'(PCLoad), 0);
    chk("mid_rst_addr", 32'(PCLoadAddr), 0);
    chk("mid_rst_ct", 32'(CycleCt), 0);
    for (int s = 0; s < 4; s++) begin
      StatSel = 2'(s);
      #1 chk("mid_rst_stat", 32'(StatCycles), 0);
    end
    @(negedge Clk);
    Reset = 1'b0;

    // Saturation on the 4-bit counter instance.
    @(negedge Clk);
    begin
      exp_t e;
      e.ct = 15;
      e.to = 0;
      qb.push_back(e);
    end
    b_start = 1'b1;
    @(negedge Clk);
    chk("b_load_pcload", 32'(b_pc_load), 1);
    b_start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (c == 17) begin
        chk("b_sat_mid_ct", 32'(b_cycle_ct), 15);
        chk("b_sat_mid_busy", 32'(b_busy), 1);
      end
    end
    b_halt = 1'b1;
    @(negedge Clk);
    b_halt = 1'b0;
    chk("b_sat_ack", 32'(b_ack), 1);

    repeat (2) @(negedge Clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
